// File: rtl/python_sync_pkg.sv
// Python LVDS sync/training code words in 10-bit form.
// Provides a helper that adapts them to the configured word width.
package python_sync_pkg;

  localparam logic [9:0] CODE_FS  = 10'h2AA;
  localparam logic [9:0] CODE_FE  = 10'h3AA;
  localparam logic [9:0] CODE_LS  = 10'h0AA;
  localparam logic [9:0] CODE_LE  = 10'h12A;
  localparam logic [9:0] CODE_BL  = 10'h015;
  localparam logic [9:0] CODE_IMG = 10'h035;
  localparam logic [9:0] CODE_TR  = 10'h3A6;

  // 8-bit mode drops the two LSBs of each 10-bit code.
  function automatic logic [9:0] sync_code(input int data_width, input logic [9:0] code10);
    return (data_width == 8) ? (code10 >> 2) : code10;
  endfunction

endpackage

// File: rtl/python_line_tracker.sv
// Frame edge detection, line counting, and first/last/black line and error flags.
// Latency: flags are combinational on the stage-1 word; counter/height registered.
// Backpressure: none; the stream advances every cycle.
module python_line_tracker #(
  parameter int LINE_CNT_WIDTH = 16,
  parameter int BLACK_LINES    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_fval,
  input  logic                      i_lval,
  input  logic [LINE_CNT_WIDTH-1:0] iv_line_total,
  input  logic                      fval_cur,
  input  logic                      act_cur,
  output logic                      fval_in,
  output logic                      act_next,
  output logic                      line_start,
  output logic                      line_end,
  output logic                      first_line,
  output logic                      last_line,
  output logic                      black_line,
  output logic                      err
);

  logic                      ign;
  logic                      fval_prev;
  logic                      act_prev;
  logic                      rise;
  logic                      fall;
  logic [LINE_CNT_WIDTH-1:0] cnt;
  logic [LINE_CNT_WIDTH-1:0] height;

  // A frame already running when reset drops stays masked until fval goes low.
  assign fval_in    = i_fval & ~ign;
  assign act_next   = fval_in & i_lval;
  assign rise       = fval_in & ~fval_cur;
  assign fall       = fval_prev & ~fval_cur;
  assign line_start = act_cur & ~act_prev;
  assign line_end   = act_cur & ~act_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      ign       <= 1'b1;
      fval_prev <= 1'b0;
      act_prev  <= 1'b0;
      cnt       <= '0;
      height    <= '0;
    end else begin
      if (!i_fval) ign <= 1'b0;
      fval_prev <= fval_cur;
      act_prev  <= act_cur;
      if (rise) begin
        cnt    <= '0;
        height <= iv_line_total;
      end else if (line_end && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign first_line = (cnt == '0);
  assign last_line  = (height != '0) && (cnt == height - 1'b1);
  assign err        = (line_start & line_end) | (fall & (cnt != height));

  if (BLACK_LINES > 0) begin : g_black
    assign black_line = (cnt < LINE_CNT_WIDTH'(BLACK_LINES));
  end else begin : g_no_black
    assign black_line = 1'b0;
  end

endmodule

// File: rtl/python_sync_encoder.sv
// Formats an fval/lval/pixel stream into Python LVDS data + sync channel words.
// Latency: 2 cycles on every output; stage 2 gives one word of lookahead.
// Backpressure: none; one word accepted and emitted every cycle.
module python_sync_encoder
  import python_sync_pkg::*;
#(
  parameter int DATA_WIDTH     = 10,
  parameter int CHANNEL_NUM    = 4,
  parameter int LINE_CNT_WIDTH = 16,
  parameter int BLACK_LINES    = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_fval,
  input  logic                              i_lval,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic [LINE_CNT_WIDTH-1:0]         iv_line_total,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic [DATA_WIDTH-1:0]             ov_sync,
  output logic                              o_err
);

  localparam int PW = DATA_WIDTH * CHANNEL_NUM;

  localparam logic [DATA_WIDTH-1:0] C_FS  = DATA_WIDTH'(sync_code(DATA_WIDTH, CODE_FS));
  localparam logic [DATA_WIDTH-1:0] C_FE  = DATA_WIDTH'(sync_code(DATA_WIDTH, CODE_FE));
  localparam logic [DATA_WIDTH-1:0] C_LS  = DATA_WIDTH'(sync_code(DATA_WIDTH, CODE_LS));
  localparam logic [DATA_WIDTH-1:0] C_LE  = DATA_WIDTH'(sync_code(DATA_WIDTH, CODE_LE));
  localparam logic [DATA_WIDTH-1:0] C_BL  = DATA_WIDTH'(sync_code(DATA_WIDTH, CODE_BL));
  localparam logic [DATA_WIDTH-1:0] C_IMG = DATA_WIDTH'(sync_code(DATA_WIDTH, CODE_IMG));
  localparam logic [DATA_WIDTH-1:0] C_TR  = DATA_WIDTH'(sync_code(DATA_WIDTH, CODE_TR));

  logic          fval_in;
  logic          act_next;
  logic          line_start;
  logic          line_end;
  logic          first_line;
  logic          last_line;
  logic          black_line;
  logic          err;
  logic          s1_fval;
  logic          s1_act;
  logic [PW-1:0] s1_pix;
  logic [DATA_WIDTH-1:0] sync_d;
  logic [PW-1:0]         pix_d;

  python_line_tracker #(
    .LINE_CNT_WIDTH (LINE_CNT_WIDTH),
    .BLACK_LINES    (BLACK_LINES)
  ) u_line_tracker (
    .clk           (clk),
    .reset         (reset),
    .i_fval        (i_fval),
    .i_lval        (i_lval),
    .iv_line_total (iv_line_total),
    .fval_cur      (s1_fval),
    .act_cur       (s1_act),
    .fval_in       (fval_in),
    .act_next      (act_next),
    .line_start    (line_start),
    .line_end      (line_end),
    .first_line    (first_line),
    .last_line     (last_line),
    .black_line    (black_line),
    .err           (err)
  );

  // Stage 1 holds the word being coded; the live input is its successor.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_fval <= 1'b0;
      s1_act  <= 1'b0;
      s1_pix  <= '0;
    end else begin
      s1_fval <= fval_in;
      s1_act  <= act_next;
      s1_pix  <= iv_pix_data;
    end
  end

  always_comb begin
    sync_d = C_TR;
    pix_d  = {CHANNEL_NUM{C_TR}};
    if (s1_act) begin
      pix_d = s1_pix;
      if (line_start)    sync_d = first_line ? C_FS : C_LS;
      else if (line_end) sync_d = last_line  ? C_FE : C_LE;
      else               sync_d = black_line ? C_BL : C_IMG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_fval      <= 1'b0;
      o_lval      <= 1'b0;
      ov_pix_data <= {CHANNEL_NUM{C_TR}};
      ov_sync     <= C_TR;
      o_err       <= 1'b0;
    end else begin
      o_fval      <= s1_fval;
      o_lval      <= s1_act;
      ov_pix_data <= pix_d;
      ov_sync     <= sync_d;
      o_err       <= err;
    end
  end

endmodule

// File: tb/tb_python_sync_encoder.sv
// Scoreboard bench: a 10-bit/4-ch encoder and an 8-bit/2-ch/1-black-line encoder
// share one directed stimulus stream; expected words are queued and checked 2 cycles later.
module tb_python_sync_encoder;

  localparam logic [9:0] FS = 10'h2AA, FE = 10'h3AA, LS = 10'h0AA, LE = 10'h12A;
  localparam logic [9:0] BL = 10'h015, IMG = 10'h035, TR = 10'h3A6;

  typedef struct {
    int          due;
    bit          fval;
    bit          lval;
    bit          err;
    logic [9:0]  code;
    logic [9:0]  code_b;
    logic [39:0] pix;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_fval, i_lval;
  logic [39:0] pix;
  logic [15:0] line_total;
  logic        a_fval, a_lval, a_err, b_fval, b_lval, b_err;
  logic [39:0] a_pix;
  logic [9:0]  a_sync;
  logic [15:0] b_pix;
  logic [7:0]  b_sync;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mask = 1'b0;
  logic [15:0] lt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  python_sync_encoder #(
    .DATA_WIDTH(10), .CHANNEL_NUM(4), .LINE_CNT_WIDTH(16), .BLACK_LINES(0)
  ) dut_a (
    .clk(clk), .reset(reset), .i_fval(i_fval), .i_lval(i_lval),
    .iv_pix_data(pix), .iv_line_total(line_total),
    .o_fval(a_fval), .o_lval(a_lval), .ov_pix_data(a_pix), .ov_sync(a_sync), .o_err(a_err)
  );

  python_sync_encoder #(
    .DATA_WIDTH(8), .CHANNEL_NUM(2), .LINE_CNT_WIDTH(16), .BLACK_LINES(1)
  ) dut_b (
    .clk(clk), .reset(reset), .i_fval(i_fval), .i_lval(i_lval),
    .iv_pix_data(pix[15:0]), .iv_line_total(line_total),
    .o_fval(b_fval), .o_lval(b_lval), .ov_pix_data(b_pix), .ov_sync(b_sync), .o_err(b_err)
  );

  function automatic logic [7:0] code8(input logic [9:0] c);
    case (c)
      10'h2AA: return 8'hAA;
      10'h3AA: return 8'hEA;
      10'h0AA: return 8'h2A;
      10'h12A: return 8'h4A;
      10'h015: return 8'h05;
      10'h035: return 8'h0D;
      10'h3A6: return 8'hE9;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares the DUT outputs against the entry due this cycle.
  always @(negedge clk) begin : monitor
    exp_t x;
    while (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_entry at cycle %0d: due %0d, required due >= %0d", cyc, q[0].due, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      x = q.pop_front();
      chk("a_fval", 64'(a_fval), 64'(x.fval));
      chk("a_lval", 64'(a_lval), 64'(x.lval));
      chk("a_sync", 64'(a_sync), 64'(x.code));
      chk("a_pix",  64'(a_pix),  x.lval ? 64'(x.pix) : 64'({4{TR}}));
      chk("a_err",  64'(a_err),  64'(x.err));
      chk("b_fval", 64'(b_fval), 64'(x.fval));
      chk("b_lval", 64'(b_lval), 64'(x.lval));
      chk("b_sync", 64'(b_sync), 64'(code8(x.code_b)));
      chk("b_pix",  64'(b_pix),  x.lval ? 64'(x.pix[15:0]) : 64'(16'hE9E9));
      chk("b_err",  64'(b_err),  64'(x.err));
    end
  end

  task automatic step(input bit f, input bit l, input logic [9:0] ca, input logic [9:0] cb, input bit e);
    exp_t        x;
    logic [63:0] r;
    @(posedge clk); #1;
    r = {$urandom, $urandom};
    reset = 1'b0; i_fval = f; i_lval = l; pix = r[39:0]; line_total = lt;
    x.due = cyc + 2; x.fval = f & ~mask; x.lval = f & l & ~mask;
    x.err = e; x.code = ca; x.code_b = cb; x.pix = r[39:0];
    q.push_back(x);
  endtask

  task automatic do_reset();
    exp_t x;
    @(posedge clk); #1;
    reset = 1'b1;
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    x.due = cyc + 1; x.fval = 0; x.lval = 0; x.err = 0;
    x.code = TR; x.code_b = TR; x.pix = '0;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, TR, TR, 0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1, 0, TR, TR, 0);
  endtask

  task automatic frame_begin(input logic [15:0] total);
    lt = total;
    step(1, 0, TR, TR, 0);
  endtask

  task automatic line(input int len, input logic [9:0] st, input logic [9:0] mid_a,
                      input logic [9:0] mid_b, input logic [9:0] en);
    if (len == 1) begin
      step(1, 1, st, st, 1);
    end else begin
      step(1, 1, st, st, 0);
      for (int i = 0; i < len - 2; i++) step(1, 1, mid_a, mid_b, 0);
      step(1, 1, en, en, 0);
    end
  endtask

  initial begin
    reset = 1'b1; i_fval = 0; i_lval = 0; pix = '0; line_total = '0;
    do_reset();
    idle(3);

    // Height 3 with a mid-frame height change that must be ignored.
    frame_begin(3); lt = 16'd7;
    line(4, FS, IMG, BL, LE); gap(2);
    line(4, LS, IMG, IMG, LE); gap(2);
    line(4, LS, IMG, IMG, FE); gap(2);
    step(0, 0, TR, TR, 0); idle(2);

    // lval without fval is blanking.
    step(0, 1, TR, TR, 0); step(0, 1, TR, TR, 0); idle(2);

    // Height 4, only 3 lines: no FE, error at fval fall.
    frame_begin(4);
    line(4, FS, IMG, BL, LE); gap(2);
    line(4, LS, IMG, IMG, LE); gap(2);
    line(4, LS, IMG, IMG, LE); gap(2);
    step(0, 0, TR, TR, 1); idle(2);

    // One-word line in the middle of a frame.
    frame_begin(3);
    line(4, FS, IMG, BL, LE); gap(2);
    line(1, LS, IMG, IMG, LS); gap(2);
    line(4, LS, IMG, IMG, FE); gap(2);
    step(0, 0, TR, TR, 0); idle(2);

    // One-word line that is both first and last line.
    frame_begin(1);
    line(1, FS, IMG, IMG, FS); gap(1);
    step(0, 0, TR, TR, 0); idle(2);

    // Height 0: every line ends LE, error at fall.
    frame_begin(0);
    line(4, FS, IMG, BL, LE); gap(2);
    line(4, LS, IMG, IMG, LE); gap(2);
    step(0, 0, TR, TR, 1); idle(2);

    // Back-to-back frames with a single low fval cycle.
    frame_begin(1);
    line(4, FS, IMG, BL, FE);
    step(0, 0, TR, TR, 0);
    line(4, FS, IMG, BL, FE); gap(1);
    step(0, 0, TR, TR, 0); idle(2);

    // Reset mid-line; the in-progress frame stays masked until fval falls.
    frame_begin(3);
    step(1, 1, FS, FS, 0);
    step(1, 1, IMG, BL, 0);
    do_reset();
    mask = 1'b1;
    step(1, 1, TR, TR, 0); step(1, 1, TR, TR, 0); step(1, 1, TR, TR, 0);
    mask = 1'b0;
    idle(2);
    frame_begin(2);
    line(4, FS, IMG, BL, LE); gap(2);
    line(4, LS, IMG, IMG, FE); gap(2);
    step(0, 0, TR, TR, 0); idle(3);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/python_sync_encoder.md
# python_sync_encoder

Parametrised successor to the Python pixel formatter in the sensor testbench model. Takes a parallel fval/lval/pixel stream and produces a Python-style LVDS word stream: data channels carry pixels during active lines and the training word elsewhere, and a separate sync channel carries frame/line start/end, image, black-line and training codes. The block sits between the pattern generator and the serializer model. It also flags frames whose line count does not match the programmed height.

## Interface
- DATA_WIDTH, 10: word width; 8 or 10 only.
- CHANNEL_NUM, 4: data channel count, ≥1.
- LINE_CNT_WIDTH, 16: line counter and height width.
- BLACK_LINES, 0: number of leading lines per frame coded as black (BL) instead of IMG.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_fval  in  1  frame valid.
- i_lval  in  1  line valid; qualified by i_fval.
- iv_pix_data  in  DATA_WIDTH*CHANNEL_NUM  pixel data; channel 0 in the LSBs.
- iv_line_total  in  LINE_CNT_WIDTH  expected lines per frame; sampled on the i_fval rising edge.
- o_fval  out  1  delayed i_fval.
- o_lval  out  1  delayed (i_fval & i_lval).
- ov_pix_data  out  DATA_WIDTH*CHANNEL_NUM  formatted data.
- ov_sync  out  DATA_WIDTH  sync channel code.
- o_err  out  1  one-cycle pulse on a protocol or height error.

## Operation
- Codes for 10-bit mode: FS 0x2AA, FE 0x3AA, LS 0x0AA, LE 0x12A, BL 0x015, IMG 0x035, TR 0x3A6.
- 8-bit mode uses each 10-bit code >>2: FS 0xAA, FE 0xEA, LS 0x2A, LE 0x4A, BL 0x05, IMG 0x0D, TR 0xE9.
- Active word = fval&lval. Each word's code is chosen using the previous and the next active flag, in this priority:
  - Not active: sync=TR; every data channel=TR.
  - Previous word not active (line start): FS on line 0 of the frame, otherwise LS.
  - Next word not active (line end): FE on line iv_line_total-1, otherwise LE.
  - Otherwise: BL while line index < BLACK_LINES, else IMG.
  - Data channels carry the pixel word for every active word.
- One-word line: emit the start code only and pulse o_err.
- Line counter:
  - Cleared on the i_fval rising edge.
  - Increments on each line end; saturates at all-ones.
  - Height is latched at the i_fval rising edge. A mid-frame change to iv_line_total has no effect.
- iv_line_total=0: FE is never emitted; all line ends use LE.
- i_fval falling with the counter ≠ latched height: o_err pulses together with the output cycle of the fval fall.
- i_lval high while i_fval low: treated as inactive, with no error.

## Timing
- Latency is 2 cycles on every output, with o_fval/o_lval aligned to their data/sync. The second stage provides the next-word lookahead.
- Reset values: o_fval=0, o_lval=0, o_err=0, ov_sync=TR, ov_pix_data={CHANNEL_NUM{TR}}. Counter and pipeline are cleared.
- Reset mid-frame: outputs go to reset values on the next edge. The next frame's codes begin from the next i_fval rising edge after reset is released. A frame already in progress when reset is released is ignored until i_fval falls.
- Back-to-back frames (i_fval low for 1 cycle) are supported: the counter clears on the new rising edge with no lost line.

## Structure
- Package python_sync_pkg holds the 10-bit code constants and a function returning a code for a given DATA_WIDTH.
- Sub-module python_line_tracker contains:
  - the edge detection;
  - the line counter and latched height;
  - the first-line, last-line, black-line and o_err generation.
- The top level holds the 2-stage pipeline and the code mux.

## Test plan
- 10-bit, 4 channels, height 3, lines of 4 words with 2-cycle gaps. Sync sequence must be:
  - line 0: FS, IMG, IMG, LE;
  - line 1: LS, IMG, IMG, LE;
  - line 2: LS, IMG, IMG, FE;
  - TR on all gaps; data equals input delayed by 2; o_err never pulses.
- 8-bit mode, same frame: codes 0xAA/0x2A/0x0D/0x4A/0xEA; blanking words are 0xE9 on every data channel.
- BLACK_LINES=1, height 2: line 0 middle words are BL (0x015), line 1 middle words are IMG.
- Height programmed as 4 but only 3 lines sent: line 2 ends with LE, and o_err pulses once at the output cycle of the fval fall.
- One-word line inside a frame: sync=LS (or FS on line 0) for that word and o_err pulses once. Reset asserted mid-line: the next cycle shows reset values, and the following frame starts with FS.
- iv_line_total=0 with 2 lines: both lines end with LE and o_err pulses at frame end.
